// File: rtl/trigger_capture_if.sv
// Signal bundle between a capture client and trigger_capture: sample input,
// capture control/status and the readout stream.
interface trigger_capture_if #(
  parameter int AW = 10
) ();
  logic [15:0]   adc;
  logic          sample_en;
  logic          trig_condition;
  logic          arm;
  logic          abort;
  logic [AW-1:0] pre_len;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;

  modport master (
    output adc, sample_en, trig_condition, arm, abort, pre_len, rd_ready,
    input  busy, done, trig_addr, rd_data, rd_valid, rd_last
  );

  modport slave (
    input  adc, sample_en, trig_condition, arm, abort, pre_len, rd_ready,
    output busy, done, trig_addr, rd_data, rd_valid, rd_last
  );
endinterface

// File: rtl/trigger_capture.sv
// Pre/post-trigger ADC capture into a circular buffer, then a DEPTH-beat
// valid/ready readout starting pre_len samples before the trigger.
module trigger_capture #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input logic              clk,
  input logic              reset,
  trigger_capture_if.slave bus
);

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, READ} state_t;

  state_t              state;
  logic                busy;
  logic                done;
  logic [AW-1:0]       trig_addr;
  logic [AW-1:0]       pre_len_q;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       cnt;
  logic [AW-1:0]       rd_addr;
  logic [AW:0]         iss_cnt;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   data_p1;
  logic                vld_p1;
  logic                last_p1;
  logic [DATA_W-1:0]   skid_data;
  logic                skid_vld;
  logic                skid_last;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                rd_last;

  logic                we;
  logic                pop;
  logic                issue;
  logic [1:0]          occ;
  logic [AW-1:0]       post_len;
  logic                skid_load;
  logic                rd_from_skid;
  logic                rd_from_p1;

  assign we       = bus.sample_en && (state == PRE || state == WAIT || state == POST);
  assign pop      = rd_valid && bus.rd_ready;
  assign post_len = {AW{1'b1}} - pre_len_q;

  // Credit check: head + skid hold two beats, so never have more than two
  // beats buffered or in flight through the RAM read register.
  assign occ      = 2'(rd_valid) + 2'(skid_vld) + 2'(vld_p1);
  assign issue    = (state == READ) && !bus.abort &&
                    (iss_cnt != (AW+1)'(DEPTH)) && ((occ - 2'(pop)) < 2'd2);

  assign rd_from_skid = pop && skid_vld;
  assign rd_from_p1   = vld_p1 && (pop ? !skid_vld : !rd_valid);
  assign skid_load    = vld_p1 && (pop ? skid_vld : rd_valid);

  // Stage p0 -> p1: buffer write and registered RAM read; skid payload
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= bus.adc;
    if (issue) data_p1 <= mem[rd_addr];
    if (skid_load) skid_data <= data_p1;
  end

  // Control FSM, read issue and p1 -> skid -> output beat movement
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      trig_addr <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      pre_len_q <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      rd_addr   <= '0;
      iss_cnt   <= '0;
    end else if (bus.abort && state != IDLE) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      skid_vld <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      vld_p1  <= issue;
      last_p1 <= issue && (iss_cnt == (AW+1)'(DEPTH - 1));
      case (state)
        IDLE: begin
          if (bus.arm && !bus.abort) begin
            pre_len_q <= bus.pre_len;
            wr_ptr    <= '0;
            cnt       <= '0;
            iss_cnt   <= '0;
            busy      <= 1'b1;
            state     <= (bus.pre_len == '0) ? WAIT : PRE;
          end
        end
        PRE: begin
          if (bus.sample_en) begin
            cnt <= cnt + 1'b1;
            if (cnt == pre_len_q - 1'b1) state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.sample_en && bus.trig_condition) begin
            trig_addr <= wr_ptr;
            rd_addr   <= wr_ptr - pre_len_q;
            cnt       <= post_len;
            state     <= (post_len == '0) ? READ : POST;
          end
        end
        POST: begin
          if (bus.sample_en) begin
            cnt <= cnt - 1'b1;
            if (cnt == 1) state <= READ;
          end
        end
        READ: begin
          if (issue) begin
            rd_addr <= rd_addr + 1'b1;
            iss_cnt <= iss_cnt + 1'b1;
          end
          if (rd_from_skid) begin
            rd_data <= skid_data;
            rd_last <= skid_last;
          end else if (rd_from_p1) begin
            rd_data <= data_p1;
            rd_last <= last_p1;
          end
          rd_valid <= rd_from_skid || rd_from_p1 || (rd_valid && !pop);
          if (skid_load) begin
            skid_vld  <= 1'b1;
            skid_last <= last_p1;
          end else if (rd_from_skid) begin
            skid_vld <= 1'b0;
          end
          if (pop && rd_last) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            skid_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.trig_addr = trig_addr;
  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_last   = rd_last;

endmodule

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, capture buffer depth in samples; power of two, minimum 4.
REQ-002 SHALL have parameter AW, default 10, address width; equals log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port adc  input  16  ADC sample, valid when sample_en=1.
REQ-006 SHALL have port sample_en  input  1  sample strobe; one sample per cycle where high.
REQ-007 SHALL have port trig_condition  input  1  trigger flag from trigger_unit, aligned with adc.
REQ-008 SHALL have port arm  input  1  single-cycle capture start request.
REQ-009 SHALL have port abort  input  1  cancel capture or readout.
REQ-010 SHALL have port pre_len  input  AW  number of pre-trigger samples, 0..DEPTH-1.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last readout beat.
REQ-013 SHALL have port trig_addr  output  AW  buffer address of the trigger sample.
REQ-014 SHALL have port rd_data  output  16  readout sample.
REQ-015 SHALL have port rd_valid  output  1  readout data valid.
REQ-016 SHALL have port rd_ready  input  1  downstream accepts readout beat.
REQ-017 SHALL have port rd_last  output  1  marks the final (DEPTH-th) readout beat.

Function
REQ-018 SHALL implement states IDLE, PRE, WAIT, POST and READ.
REQ-019 IDLE: on arm, SHALL latch pre_len, clear wr_ptr and counters, and enter PRE, or enter WAIT if pre_len=0; arm outside IDLE SHALL be ignored.
REQ-020 Any write state (PRE/WAIT/POST) with sample_en=1: SHALL write adc to buffer[wr_ptr] and increment wr_ptr modulo DEPTH.
REQ-021 PRE: SHALL enter WAIT on the cycle that writes the pre_len-th sample; trig_condition SHALL be ignored in PRE.
REQ-022 WAIT: a sample written with trig_condition=1 SHALL be the trigger sample.
REQ-023 WAIT: on the trigger sample, trig_addr SHALL take the write address and the block SHALL enter POST with DEPTH-pre_len-1 samples remaining.
REQ-024 WAIT: trig_condition while sample_en=0 SHALL be ignored.
REQ-025 WAIT: the buffer wraps freely; the oldest samples are overwritten.
REQ-026 POST: SHALL enter READ after the last remaining sample is written; if the remaining count is 0, SHALL go straight from WAIT to READ.
REQ-027 READ: SHALL stream DEPTH samples starting at address (trig_addr-pre_len) mod DEPTH, incrementing with wrap.
REQ-028 READ: rd_valid SHALL assert no later than 2 cycles after READ entry.
REQ-029 A readout beat SHALL transfer when rd_valid and rd_ready are both high; no drops or duplicates.
REQ-030 rd_data and rd_last SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-031 Readout SHALL sustain one beat per cycle while rd_ready is held high.
REQ-032 rd_last SHALL be high only with the DEPTH-th beat; after that transfer, the block SHALL go to IDLE, rd_valid SHALL be 0 and done SHALL pulse 1 for exactly one cycle.
REQ-033 abort in any non-IDLE state SHALL return the block to IDLE on the next edge, with rd_valid=0, busy=0 and no done pulse.
REQ-034 abort and arm in the same cycle SHALL give abort priority.
REQ-035 Changes to pre_len after arm SHALL have no effect until the next arm.
REQ-036 The buffer SHALL be an inferred single-clock RAM with registered read; readout latency SHALL be hidden by prefetch or skid logic.

Reset
REQ-037 On reset=1 at a clock edge, state SHALL be IDLE and busy, done, rd_valid, rd_last, trig_addr and rd_data SHALL all be 0.
REQ-038 Reset SHALL override every input, including mid-capture or mid-readout; buffer contents need not be cleared.
REQ-039 After reset deasserts, the block SHALL accept arm on the first cycle.

Verification (DEPTH=16, sample_en=1 continuously, adc=ramp counting from 0x0000 starting at arm+1 cycle)
REQ-040 pre_len=4, trig_condition high only at adc=0x0009 -> trig_addr=9; 16 beats 0x0005..0x0014; rd_last on 0x0014; done pulse once.
REQ-041 pre_len=0, trigger at adc=0x0003 -> WAIT entered directly; readout 0x0003..0x0012.
REQ-042 pre_len=4, trig_condition high for adc 0x0000..0x0003, then at 0x0009 only -> PRE triggers ignored; readout identical to REQ-040.
REQ-043 REQ-040 setup, rd_ready random 50% -> same 16-value sequence in order; rd_data stable during every stall.
REQ-044 abort asserted during POST -> busy=0 next cycle, rd_valid never asserts, done stays 0; an immediate re-arm completes the REQ-040 case.
REQ-045 reset asserted on the 5th readout beat -> all outputs 0 next cycle; a subsequent arm completes normally.
